// File: rtl/temporizador_n_if.sv
// Control/status bundle between a timer and the controller that arms it.
// master = controller + tick source, slave = the timer itself.
interface temporizador_n_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] load_val;
    logic         auto_reload;
    logic         tick;
    logic         busy;
    logic         done_tick;
    logic [N-1:0] q;

    modport master (
        output start, load_val, auto_reload, tick,
        input  busy, done_tick, q
    );

    modport slave (
        input  start, load_val, auto_reload, tick,
        output busy, done_tick, q
    );
endinterface

// File: rtl/temporizador_n.sv
// Loadable down-counting timer with optional auto-reload; done_tick pulses on expiry.
// Latency: q/busy valid one edge after start; no backpressure, ticks are consumed whenever RUN.
module temporizador_n #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              soft_reset,
    temporizador_n_if.slave   tmr
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] reload_q, reload_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (soft_reset) begin
            state_d  = IDLE;
            q_d      = '0;
            reload_d = '0;
            mode_d   = 1'b0;
        end else if (tmr.start) begin
            // Re-arm abandons any running count silently; a zero load expires at once.
            reload_d = tmr.load_val;
            mode_d   = tmr.auto_reload;
            if (tmr.load_val != '0) begin
                q_d     = tmr.load_val;
                state_d = RUN;
            end else begin
                q_d     = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && tmr.tick) begin
            if (q_q == {{(N-1){1'b0}}, 1'b1}) begin
                done_d = 1'b1;
                if (mode_q) begin
                    q_d = reload_q;
                end else begin
                    q_d     = '0;
                    state_d = IDLE;
                end
            end else begin
                q_d = q_q - 1'b1;
            end
        end
    end

    assign tmr.busy      = (state_q == RUN);
    assign tmr.done_tick = done_q;
    assign tmr.q         = q_q;
endmodule

// File: tb/tb_temporizador_n.sv
module tb_temporizador_n;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic soft_reset = 1'b0;

    temporizador_n_if #(.N(8)) bus ();

    temporizador_n #(.N(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_reset (soft_reset),
        .tmr        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: a started timer of length L has seen 'ticks' ticks;
    // it expires each time ticks reaches a multiple of L.
    bit m_active = 0;
    bit m_per    = 0;
    int m_len    = 0;
    int m_ticks  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic step(input logic s, input int lv, input logic ar, input logic t, input logic sr);
        exp_t e;
        @(negedge clk);
        bus.start       = s;
        bus.load_val    = lv[7:0];
        bus.auto_reload = ar;
        bus.tick        = t;
        soft_reset      = sr;
        e.done = 1'b0;
        if (sr) begin
            m_active = 0; m_per = 0; m_len = 0; m_ticks = 0;
        end else if (s) begin
            m_len = lv; m_per = ar; m_ticks = 0;
            m_active = (lv != 0);
            e.done = (lv == 0);
        end else if (m_active && t) begin
            m_ticks++;
            if (m_ticks % m_len == 0) begin
                e.done = 1'b1;
                if (!m_per) m_active = 0;
            end
        end
        e.busy = m_active;
        e.q    = m_active ? 8'(m_len - (m_ticks % m_len)) : 8'd0;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.load_val = 8'd0; bus.auto_reload = 1'b0;
        bus.tick = 1'b0; soft_reset = 1'b0;
    endtask

    // Monitor: one registered output set per edge, compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("q", int'(bus.q), int'(e.q));
                check("busy", int'(bus.busy), int'(e.busy));
                check("done_tick", int'(bus.done_tick), int'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_q", int'(bus.q), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done_tick), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot of 3, tick every 4th cycle, trailing ticks must not disturb q.
        step(1, 3, 0, 0, 0);
        for (int i = 1; i <= 20; i++) step(0, 0, 0, (i % 4) == 0, 0);

        // Periodic divide-by-4 with continuous tick.
        step(1, 4, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // Zero load expires immediately without entering RUN.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Re-arm with simultaneous tick, then soft_reset beating start.
        step(1, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(1, 6, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 7, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Full-scale one-shot.
        step(1, 255, 0, 0, 0);
        for (int i = 0; i < 258; i++) step(0, 0, 0, 1, 0);

        // Asynchronous reset mid-count at q=5, between clock edges.
        step(1, 9, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        @(negedge clk);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_q", int'(bus.q), 0);
        check("async_busy", int'(bus.busy), 0);
        check("async_done", int'(bus.done_tick), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_active = 0; m_per = 0; m_len = 0; m_ticks = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int lv;
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            step($urandom_range(0, 19) == 0, lv, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/temporizador_n.md
Name: temporizador_n

Overview:
Loadable down-counting timer. It consumes the periodic tick produced by the team's free-running up-counters and reports expiry.
- A controller arms it with a start pulse and a count value.
- It decrements once per tick and pulses done_tick on expiry.
- Optional auto-reload makes it a periodic tick divider.
- It sits between a tick generator and FSMs that need timeouts or delays.

Parameters:
N, 8, width of count, load value and q.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous reset, active-low.
soft_reset  input  1  synchronous clear, active-high.
start  input  1  arm/re-arm request, sampled on rising edge.
load_val  input  N  count value, sampled only when start is accepted.
auto_reload  input  1  periodic mode, sampled only when start is accepted.
tick  input  1  decrement enable; single-cycle pulse from tick source.
busy  output  1  high while counting (RUN state).
done_tick  output  1  one-cycle expiry pulse, registered.
q  output  N  current remaining count.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, q=0, busy=0, done_tick=0.
  - Internal reload register and mode bit = 0.
  - Reset takes effect immediately, mid-count included; no done_tick is generated.
- Priority at each rising edge: soft_reset > start > tick.
- soft_reset=1: same end state as reset_n, applied synchronously at the edge.
- FSM has two states: IDLE and RUN. busy = (state==RUN), decoded from the state register.
- done_tick defaults to 0 every cycle unless set below, so it is never high for two consecutive cycles from a single expiry.
- IDLE, start=1:
  - Latch load_val into the reload register and auto_reload into the mode bit.
  - If load_val!=0: q<=load_val, go to RUN.
  - If load_val==0: q stays 0, done_tick<=1, stay IDLE (immediate expiry, 1-cycle latency).
- IDLE, start=0: hold; tick is ignored.
- RUN, start=1 (re-arm): identical to the IDLE start action. The in-progress count is abandoned, no done_tick is issued for it, and a simultaneous tick is ignored.
- RUN, tick=1, q>1: q<=q-1.
- RUN, tick=1, q==1:
  - done_tick<=1.
  - Mode bit 0: q<=0, go to IDLE.
  - Mode bit 1: q<=reload register, stay RUN (period = reload ticks).
- RUN, tick=0: hold.
- Latency:
  - start at edge k: q and busy valid after edge k.
  - Expiry: done_tick is high in the cycle immediately after the edge that consumed the final tick, the same cycle q first shows 0 (one-shot mode).
- Arithmetic: N-bit unsigned. Decrement never occurs from 0, so there is no underflow wrap. In RUN, q is never 0.
- Full-scale load (2**N-1) counts 2**N-1 ticks.
- load_val and auto_reload changing after start have no effect until the next accepted start.

Test Plan:
- reset_n low mid-count (q=5, RUN) -> q=0, busy=0, done_tick=0 immediately, without waiting for a clock; after release no activity until start.
- N=8, start with load_val=3, auto_reload=0, tick every 4th cycle -> q goes 3,2,1,0; busy high from the edge after start until the 3rd tick; one done_tick exactly when q becomes 0; later ticks leave q=0.
- load_val=4, auto_reload=1, continuous tick=1 for 12 cycles -> q cycles 4,3,2,1,4,...; done_tick every 4 cycles (3 pulses); busy stays 1.
- start with load_val=0 -> done_tick high for exactly 1 cycle after the edge, busy never asserted, q=0.
- RUN with q=2: assert start(load_val=6) together with tick -> q=6, no done_tick, tick ignored. Then soft_reset together with start -> IDLE, q=0.
- load_val=255 one-shot, tick every cycle -> done_tick after exactly 255 ticks, q never wraps.
